// File: rtl/sys_defs.sv
// ---------------------------------------------------------------------------
// sys_defs -- shared types and constants for the execute-stage units.
//
// Holds the issue-side DECODER_PACKET, the result TAG, the reservation
// station release packet EX_RS_PACKET, and the multiplier pipeline stage
// record MULT_STAGE together with the default multiplier depth.
// ---------------------------------------------------------------------------
package sys_defs;

  // Default depth of the multiplier pipeline (legal: 1, 2, 4, 8).
  localparam int MULT_FU_STAGES = 4;

  localparam int TAG_W    = 6;
  localparam int RS_IDX_W = 4;

  typedef logic [TAG_W-1:0]    TAG;
  typedef logic [RS_IDX_W-1:0] RS_IDX;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'h00,
    ALU_SUB    = 5'h01,
    ALU_SLT    = 5'h02,
    ALU_SLTU   = 5'h03,
    ALU_AND    = 5'h04,
    ALU_OR     = 5'h05,
    ALU_XOR    = 5'h06,
    ALU_SLL    = 5'h07,
    ALU_SRL    = 5'h08,
    ALU_SRA    = 5'h09,
    ALU_MUL    = 5'h0A,
    ALU_MULH   = 5'h0B,
    ALU_MULHSU = 5'h0C,
    ALU_MULHU  = 5'h0D
  } ALU_FUNC;

  // Issued instruction as seen by a functional unit.
  typedef struct packed {
    ALU_FUNC alu_func;
    RS_IDX   rs_idx;
    TAG      dest_tag;
  } DECODER_PACKET;

  // Reservation station entry release.
  typedef struct packed {
    logic  remove_en;
    RS_IDX remove_idx;
  } EX_RS_PACKET;

  // One multiplier pipeline stage register.
  typedef struct packed {
    logic        valid;
    TAG          tag;
    RS_IDX       rs_idx;
    ALU_FUNC     alu_func;
    logic [63:0] mcand;
    logic [63:0] mplier;
    logic [63:0] sum;
  } MULT_STAGE;

  function automatic logic is_mult(input ALU_FUNC f);
    return (f == ALU_MUL) || (f == ALU_MULH) || (f == ALU_MULHSU) || (f == ALU_MULHU);
  endfunction

endpackage

// File: rtl/mult_stage.sv
// ---------------------------------------------------------------------------
// mult_stage -- one partial-product accumulate register of the multiplier.
//
// Stage STAGE_IDX multiplies the 64-bit multiplicand by its own chunk of the
// multiplier (64/NUM_STAGES bits), shifts the partial product into place and
// adds it to the running sum. Arithmetic is modulo 2^64.
//
// Ports:
//   clock     : rising-edge clock
//   reset     : asynchronous active-high reset (clears the whole register)
//   flush     : clears the valid bit at the next edge, overriding advance
//   advance   : load the accumulated input record; otherwise hold
//   stage_in  : record from the previous stage (or the issue side)
//   stage_out : registered record of this stage
// ---------------------------------------------------------------------------
module mult_stage
  import sys_defs::*;
#(
  parameter int NUM_STAGES = MULT_FU_STAGES,
  parameter int STAGE_IDX  = 0
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      flush,
  input  logic      advance,
  input  MULT_STAGE stage_in,
  output MULT_STAGE stage_out
);

  localparam int CHUNK_W = 64 / NUM_STAGES;
  localparam int SHIFT   = STAGE_IDX * CHUNK_W;

  logic [CHUNK_W-1:0] chunk;
  logic [63:0]        partial;
  MULT_STAGE          next_rec;

  always_comb begin
    chunk    = stage_in.mplier[SHIFT +: CHUNK_W];
    // The chunk is an unsigned digit; sign handling lives entirely in the
    // 64-bit operand extension done at issue.
    partial  = stage_in.mcand * 64'(chunk);
    next_rec = stage_in;
    next_rec.sum = stage_in.sum + (partial << SHIFT);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stage_out <= '0;
    end else if (flush) begin
      stage_out.valid <= 1'b0;
    end else if (advance) begin
      stage_out <= next_rec;
    end
  end

endmodule

// File: rtl/mult_fu.sv
// ---------------------------------------------------------------------------
// mult_fu -- pipelined 32x32 multiply functional unit (MUL/MULH/MULHSU/MULHU).
//
// Ports:
//   clock, reset      : rising-edge clock, asynchronous active-high reset
//   interrupt         : flush request; clears the pipeline, masks outputs
//   issue_en          : an issued multiply is offered this cycle
//   decoder_packet    : alu_func, rs_idx and destination tag of the offer
//   opa, opb          : 32-bit source operands
//   cdb_grant         : CDB arbiter accepts this cycle's request
//   is_stall          : offer not accepted this cycle (result blocked)
//   cdb_req/tag/value : result broadcast from the last stage
//   ex_rs_packet      : releases the reservation station entry
//
// Parameter NUM_STAGES (1, 2, 4, 8) sets latency; one accept per cycle.
//
// Build option MULT_FU_EARLY_REMOVE_EN: when defined, the RS entry is released
// in the acceptance cycle (index from decoder_packet); otherwise it is
// released when the result is granted on the CDB (index from the last stage).
// ---------------------------------------------------------------------------
module mult_fu
  import sys_defs::*;
#(
  parameter int NUM_STAGES = MULT_FU_STAGES
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          interrupt,
  input  logic          issue_en,
  input  DECODER_PACKET decoder_packet,
  input  logic [31:0]   opa,
  input  logic [31:0]   opb,
  input  logic          cdb_grant,
  output logic          is_stall,
  output logic          cdb_req,
  output TAG            cdb_tag,
  output logic [31:0]   cdb_value,
  output EX_RS_PACKET   ex_rs_packet
);

  MULT_STAGE stage_in  [NUM_STAGES];
  MULT_STAGE stage_out [NUM_STAGES];
  MULT_STAGE s0_load;
  MULT_STAGE last;

  logic    stall;
  logic    accept;
  ALU_FUNC eff_func;

  always_comb begin
    last  = stage_out[NUM_STAGES-1];
    stall = last.valid && !cdb_grant;
    // Reset is folded in so an early release cannot fire while held in reset.
    accept = issue_en && !stall && !interrupt && !reset;
  end

  // Operand extension at issue; non-multiply functions execute as MUL.
  always_comb begin
    eff_func = is_mult(decoder_packet.alu_func) ? decoder_packet.alu_func : ALU_MUL;
    s0_load          = '0;
    s0_load.valid    = accept;
    s0_load.tag      = decoder_packet.dest_tag;
    s0_load.rs_idx   = decoder_packet.rs_idx;
    s0_load.alu_func = eff_func;
    s0_load.sum      = '0;
    if (eff_func == ALU_MULHU)
      s0_load.mcand = {32'h0, opa};
    else
      s0_load.mcand = {{32{opa[31]}}, opa};
    if ((eff_func == ALU_MUL) || (eff_func == ALU_MULH))
      s0_load.mplier = {{32{opb[31]}}, opb};
    else
      s0_load.mplier = {32'h0, opb};
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign stage_in[k] = s0_load;
    end else begin : g_chain
      assign stage_in[k] = stage_out[k-1];
    end

    mult_stage #(
      .NUM_STAGES (NUM_STAGES),
      .STAGE_IDX  (k)
    ) u_stage (
      .clock     (clock),
      .reset     (reset),
      .flush     (interrupt),
      .advance   (!stall),
      .stage_in  (stage_in[k]),
      .stage_out (stage_out[k])
    );
  end

  always_comb begin
    is_stall  = stall;
    cdb_req   = last.valid && !interrupt;
    cdb_tag   = last.tag;
    cdb_value = (last.alu_func == ALU_MUL) ? last.sum[31:0] : last.sum[63:32];
  end

`ifdef MULT_FU_EARLY_REMOVE_EN
  always_comb begin
    ex_rs_packet            = '0;
    ex_rs_packet.remove_en  = accept;
    ex_rs_packet.remove_idx = accept ? decoder_packet.rs_idx : '0;
  end

  logic unused_last;
  assign unused_last = ^{last.mcand, last.mplier, last.rs_idx};
`else
  always_comb begin
    ex_rs_packet            = '0;
    ex_rs_packet.remove_en  = cdb_req && cdb_grant;
    ex_rs_packet.remove_idx = (cdb_req && cdb_grant) ? last.rs_idx : '0;
  end

  logic unused_last;
  assign unused_last = ^{last.mcand, last.mplier};
`endif

endmodule

// File: tb/tb_mult_fu.sv
// ---------------------------------------------------------------------------
// tb_mult_fu -- directed self-checking bench for mult_fu (NUM_STAGES = 4).
// ---------------------------------------------------------------------------
module tb_mult_fu;
  import sys_defs::*;

`ifdef MULT_FU_EARLY_REMOVE_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic          clock;
  logic          reset;
  logic          interrupt;
  logic          issue_en;
  DECODER_PACKET dp;
  logic [31:0]   opa;
  logic [31:0]   opb;
  logic          cdb_grant;
  logic          is_stall;
  logic          cdb_req;
  TAG            cdb_tag;
  logic [31:0]   cdb_value;
  EX_RS_PACKET   ex_rs_packet;

  int n_cmp = 0;
  int n_err = 0;

  mult_fu #(.NUM_STAGES(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .interrupt      (interrupt),
    .issue_en       (issue_en),
    .decoder_packet (dp),
    .opa            (opa),
    .opb            (opb),
    .cdb_grant      (cdb_grant),
    .is_stall       (is_stall),
    .cdb_req        (cdb_req),
    .cdb_tag        (cdb_tag),
    .cdb_value      (cdb_value),
    .ex_rs_packet   (ex_rs_packet)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input ALU_FUNC f, input TAG t, input RS_IDX rs,
                       input logic [31:0] a, input logic [31:0] b);
    issue_en    = 1'b1;
    dp.alu_func = f;
    dp.rs_idx   = rs;
    dp.dest_tag = t;
    opa         = a;
    opb         = b;
  endtask

  // One isolated operation with grant held high: checks acceptance, latency,
  // tag, value, remove timing and that no duplicate broadcast follows.
  task automatic single(input string name, input ALU_FUNC f, input TAG t, input RS_IDX rs,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int lat;
    bit found;
    drive(f, t, rs, a, b);
    #2;
    check({name, "_stall"}, is_stall, 0);
    check({name, "_rm_issue"}, ex_rs_packet.remove_en, EARLY);
    if (EARLY) check({name, "_rmidx_issue"}, ex_rs_packet.remove_idx, rs);
    step();
    issue_en = 1'b0;
    lat = 1;
    found = 1'b0;
    while (!found && lat <= 12) begin
      #2;
      if (cdb_req === 1'b1) found = 1'b1;
      else begin
        step();
        lat++;
      end
    end
    check({name, "_seen"}, found, 1);
    if (found) begin
      check({name, "_latency"}, lat, 4);
      check({name, "_tag"}, cdb_tag, t);
      check({name, "_value"}, cdb_value, exp);
      check({name, "_rm_cdb"}, ex_rs_packet.remove_en, !EARLY);
      if (!EARLY) check({name, "_rmidx_cdb"}, ex_rs_packet.remove_idx, rs);
      step();
    end
    #2;
    check({name, "_nodup"}, cdb_req, 0);
    step();
  endtask

  initial begin
    reset     = 1'b0;
    interrupt = 1'b0;
    issue_en  = 1'b0;
    dp        = '0;
    opa       = '0;
    opb       = '0;
    cdb_grant = 1'b0;
    #1 reset = 1'b1;
    step();
    check("rst_cdb_req",   cdb_req, 0);
    check("rst_is_stall",  is_stall, 0);
    check("rst_remove_en", ex_rs_packet.remove_en, 0);
    check("rst_remove_idx", ex_rs_packet.remove_idx, 0);
    check("rst_cdb_tag",   cdb_tag, 0);
    check("rst_cdb_value", cdb_value, 0);
    step();
    reset = 1'b0;
    cdb_grant = 1'b1;

    // Basic and high-half products.
    single("mul_7_m3",  ALU_MUL,    6'd5,  4'd3, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB);
    single("mulhu_ff",  ALU_MULHU,  6'd6,  4'd4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    single("mulh_ff",   ALU_MULH,   6'd7,  4'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
    single("mulhsu_ff", ALU_MULHSU, 6'd8,  4'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    single("mulh_big",  ALU_MULH,   6'd9,  4'd7, 32'h40000000, 32'h00000008, 32'h00000002);
    single("add_as_mul", ALU_ADD,   6'd10, 4'd8, 32'd5,        32'd6,        32'd30);

    // Four back-to-back issues: results in order on consecutive cycles.
    for (int i = 0; i < 4; i++) begin
      drive(ALU_MUL, TAG'(i + 1), RS_IDX'(i + 1), 32'(i + 2), 32'd3);
      #2;
      check("b2b_issue_stall", is_stall, 0);
      check("b2b_issue_rm", ex_rs_packet.remove_en, EARLY);
      step();
    end
    issue_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      check("b2b_req",   cdb_req, 1);
      check("b2b_tag",   cdb_tag, 64'(i + 1));
      check("b2b_value", cdb_value, 64'(3 * (i + 2)));
      check("b2b_stall", is_stall, 0);
      step();
    end
    #2;
    check("b2b_tail", cdb_req, 0);
    step();

    // Last stage held with grant low for three cycles.
    cdb_grant = 1'b0;
    drive(ALU_MUL, 6'd12, 4'd9, 32'd4, 32'd5);
    step();
    drive(ALU_MUL, 6'd13, 4'd10, 32'd6, 32'd7);
    #2;
    check("stl_second_acc", is_stall, 0);
    step();
    issue_en = 1'b0;
    step();
    step();
    for (int j = 0; j < 3; j++) begin
      // Offer during the stall must be refused.
      if (j == 0) drive(ALU_MUL, 6'd14, 4'd11, 32'd9, 32'd9);
      else issue_en = 1'b0;
      #2;
      check("stl_is_stall", is_stall, 1);
      check("stl_req",      cdb_req, 1);
      check("stl_tag",      cdb_tag, 12);
      check("stl_value",    cdb_value, 20);
      check("stl_rm",       ex_rs_packet.remove_en, 0);
      step();
    end
    issue_en  = 1'b0;
    cdb_grant = 1'b1;
    #2;
    check("stl_rel_stall", is_stall, 0);
    check("stl_rel_req",   cdb_req, 1);
    check("stl_rel_tag",   cdb_tag, 12);
    check("stl_rel_value", cdb_value, 20);
    check("stl_rel_rm",    ex_rs_packet.remove_en, !EARLY);
    step();
    #2;
    check("stl_next_req",   cdb_req, 1);
    check("stl_next_tag",   cdb_tag, 13);
    check("stl_next_value", cdb_value, 42);
    step();
    for (int j = 0; j < 5; j++) begin
      #2;
      check("stl_drained", cdb_req, 0);
      step();
    end

    // Interrupt with three operations in flight.
    drive(ALU_MUL, 6'd20, 4'd1, 32'd2, 32'd2);
    step();
    drive(ALU_MUL, 6'd21, 4'd2, 32'd3, 32'd3);
    step();
    drive(ALU_MUL, 6'd22, 4'd3, 32'd4, 32'd4);
    step();
    issue_en = 1'b0;
    step();
    interrupt = 1'b1;
    drive(ALU_MUL, 6'd23, 4'd4, 32'd5, 32'd5);
    #2;
    check("irq_req",   cdb_req, 0);
    check("irq_rm",    ex_rs_packet.remove_en, 0);
    step();
    interrupt = 1'b0;
    issue_en  = 1'b0;
    for (int j = 0; j < 6; j++) begin
      #2;
      check("irq_empty", cdb_req, 0);
      step();
    end

    // Reset asserted between edges with operations in flight.
    drive(ALU_MUL, 6'd30, 4'd12, 32'd10, 32'd10);
    step();
    drive(ALU_MUL, 6'd31, 4'd13, 32'd11, 32'd11);
    step();
    issue_en = 1'b0;
    step();
    step();
    check("mrst_pre_req", cdb_req, 1);
    #1 reset = 1'b1;
    #1;
    check("mrst_req",   cdb_req, 0);
    check("mrst_rm",    ex_rs_packet.remove_en, 0);
    check("mrst_value", cdb_value, 0);
    step();
    reset = 1'b0;
    single("post_rst", ALU_MUL, 6'd33, 4'd5, 32'd2, 32'd3, 32'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mult_fu.md
MULT_FU -- requirements
Module: mult_fu

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 4: pipeline depth; legal values 1, 2, 4, 8.
REQ-002 SHALL have ports `clock`, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have ports `reset`, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port `interrupt`, input, 1 bit: pipeline flush request.
REQ-005 SHALL have port `issue_en`, input, 1 bit: an issued multiply is offered in this cycle.
REQ-006 SHALL have port `decoder_packet`, input, DECODER_PACKET: issued instruction; uses alu_func, rs_idx and destination TAG.
REQ-007 SHALL have ports `opa` and `opb`, input, 32 bits each: source operand values.
REQ-008 SHALL have port `cdb_grant`, input, 1 bit: CDB arbiter accepts this cycle's request.
REQ-009 SHALL have port `is_stall`, output, 1 bit: the offer is not accepted this cycle.
REQ-010 SHALL have ports `cdb_req` (output, 1 bit), `cdb_tag` (output, TAG) and `cdb_value` (output, 32 bits): result broadcast.
REQ-011 SHALL have port `ex_rs_packet`, output, EX_RS_PACKET: remove_en and remove_idx, which frees the RS entry.

Function
REQ-012 SHALL hold NUM_STAGES stage registers S0..S(N-1), each holding: valid, tag, rs_idx, alu_func, 64-bit multiplicand, 64-bit multiplier, 64-bit partial sum.
REQ-013 SHALL, on acceptance, extend operands to 64 bits per alu_func:
- MUL and MULH: both operands signed.
- MULHSU: opa signed, opb unsigned.
- MULHU: both operands unsigned.
REQ-014 SHALL, in stage k, add (multiplicand × multiplier chunk k) << (k×64/NUM_STAGES) into the partial sum, where chunk k is bits of width 64/NUM_STAGES; the result SHALL be exact modulo 2^64.
REQ-015 SHALL drive cdb_value as the low 32 bits of the final sum for MUL, and the high 32 bits for MULH, MULHSU and MULHU.
REQ-016 SHALL set stall = S(N-1).valid && !cdb_grant, and SHALL drive is_stall = stall.
REQ-017 SHALL freeze all stages while stall is high; otherwise every stage SHALL advance one step per clock.
REQ-018 SHALL accept an offer when issue_en && !stall && !interrupt; the accepted offer loads S0, and a bubble SHALL be loaded when there is no acceptance.
REQ-019 SHALL give a latency of NUM_STAGES cycles: an offer accepted in cycle C produces cdb_req high in cycle C+NUM_STAGES if it is not stalled.
REQ-020 SHALL sustain a throughput of one accept per cycle with no bubbles when the grant is held high.
REQ-021 SHALL drive cdb_req = S(N-1).valid && !interrupt, and cdb_tag = S(N-1).tag.
REQ-022 SHALL keep cdb_req, cdb_tag and cdb_value stable until the grant.
REQ-023 SHALL, when interrupt is high, clear every stage valid bit at the next edge and accept nothing in that cycle.
REQ-024 SHALL, when interrupt is high, mask cdb_req and ex_rs_packet.remove_en in the same cycle.
REQ-025 SHALL give interrupt priority over all other inputs.
REQ-026 SHALL treat a non-multiply alu_func on an accepted offer as MUL.

Reset
REQ-027 SHALL, on reset assertion, immediately (asynchronously) clear all stage valid bits; data fields are don't-care.
REQ-028 SHALL hold these values during reset: cdb_req=0, is_stall=0, remove_en=0, remove_idx=0, cdb_tag=0, cdb_value=0.
REQ-029 SHALL discard all in-flight operations when reset is asserted mid-operation, with no broadcast and no remove for them.
REQ-030 SHALL accept a new offer in the first cycle after reset deassertion.

Configuration
REQ-031 SHALL support macro MULT_FU_EARLY_REMOVE_EN.
- When the macro is defined: remove_en SHALL be high in the acceptance cycle, with remove_idx taken from the rs_idx of decoder_packet.
- When the macro is undefined: remove_en SHALL be high in the cycle cdb_req && cdb_grant, with remove_idx taken from the rs_idx of S(N-1).
- In both cases: at most one remove SHALL occur per cycle.

Structure
REQ-032 SHALL place the MULT_STAGE struct and the MULT_FU_STAGES default constant in the shared sys_defs package, next to DECODER_PACKET, TAG and EX_RS_PACKET.
REQ-033 SHALL implement one stage as sub-module mult_stage (a partial-product accumulate register), instantiated NUM_STAGES times by mult_fu.

Verification
REQ-034 SHALL cover: MUL with opa=7, opb=0xFFFFFFFD (-3), grant held high -> cdb_req high 4 cycles after the issue, cdb_value=0xFFFFFFEB, correct tag.
REQ-035 SHALL cover the high-half products with opa=opb=0xFFFFFFFF:
- MULHU -> cdb_value=0xFFFFFFFE.
- MULH -> cdb_value=0x00000000.
- MULHSU -> cdb_value=0xFFFFFFFF.
REQ-036 SHALL cover 4 back-to-back issues with grant held high -> 4 consecutive cdb_req cycles, results in order, is_stall never high.
REQ-037 SHALL cover the last stage valid with grant low for 3 cycles -> is_stall high for 3 cycles, cdb outputs stable, no loss or duplication after the grant.
REQ-038 SHALL cover interrupt raised with 3 operations in flight -> same-cycle cdb_req=0 and remove_en=0, pipeline empty next cycle, no later broadcast.
REQ-039 SHALL cover reset asserted mid-flight between clock edges -> immediately cdb_req=0, and a fresh MUL 2×3 after release yields 6.
